// File: rtl/fetch_unit_if.sv
// Instruction-bus handshake between the fetch unit (master) and memory (slave).
// One read in flight at most: address phase via iaddr_ok, data phase via idata_ok.
interface fetch_unit_if;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iaddr_ok;
  logic        idata_ok;
  logic [31:0] irdata;

  modport master (
    output ireq,
    output iaddr,
    input  iaddr_ok,
    input  idata_ok,
    input  irdata
  );

  modport slave (
    input  ireq,
    input  iaddr,
    output iaddr_ok,
    output idata_ok,
    output irdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch stage: issues one read at pc, buffers the result for decode,
// and follows redirects and flushes. A misaligned pc yields an entry flagged with f_adel.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              resetn,
  fetch_unit_if.master      ibus,
  input  logic              i_stall,
  input  logic              i_is_jump,
  input  logic              i_is_jr,
  input  logic              i_branch_taken,
  input  logic [31:0]       i_pcjump,
  input  logic [31:0]       i_pcjr,
  input  logic [31:0]       i_pcbranch,
  input  logic              i_flush,
  input  logic [31:0]       i_flush_pc,
  output logic              o_f_valid,
  output logic [31:0]       o_f_raw_instr,
  output logic [31:0]       o_f_pc,
  output logic [31:0]       o_f_pcplus4,
  output logic              o_f_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_DROP} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_adel;

  logic        w_aligned;
  logic        w_ireq;
  logic        w_req_ok;
  logic        w_accept;
  logic [31:0] w_next_pc;

  assign w_aligned = (r_pc[1:0] == 2'b00);
  // Gated by resetn so no request is visible while reset is held.
  assign w_ireq    = resetn && (r_state == S_REQ) && w_aligned;
  assign w_req_ok  = w_ireq && ibus.iaddr_ok;
  assign w_accept  = (r_state == S_VALID) && !i_stall && !i_flush;

  // Redirects only matter in the accept cycle, where the delay slot leaves fetch.
  always_comb begin
    if (i_is_jr) begin
      w_next_pc = i_pcjr;
    end else if (i_is_jump) begin
      w_next_pc = i_pcjump;
    end else if (i_branch_taken) begin
      w_next_pc = i_pcbranch;
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_adel  <= 1'b0;
    end else begin
      if (i_flush) begin
        r_pc <= i_flush_pc;
      end else if (w_accept) begin
        r_pc <= w_next_pc;
      end

      unique case (r_state)
        S_REQ: begin
          if (i_flush) begin
            // An accepted address whose data is still outstanding must be drained.
            r_state <= (w_req_ok && !ibus.idata_ok) ? S_DROP : S_REQ;
          end else if (!w_aligned) begin
            r_state <= S_VALID;
            r_instr <= 32'h0;
            r_adel  <= 1'b1;
          end else if (w_req_ok) begin
            if (ibus.idata_ok) begin
              r_state <= S_VALID;
              r_instr <= ibus.irdata;
              r_adel  <= 1'b0;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (ibus.idata_ok) begin
            if (i_flush) begin
              r_state <= S_REQ;
            end else begin
              r_state <= S_VALID;
              r_instr <= ibus.irdata;
              r_adel  <= 1'b0;
            end
          end else if (i_flush) begin
            r_state <= S_DROP;
          end
        end
        S_VALID: begin
          if (i_flush || w_accept) begin
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (ibus.idata_ok) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign ibus.ireq     = w_ireq;
  assign ibus.iaddr    = r_pc;
  assign o_f_valid     = (r_state == S_VALID);
  assign o_f_raw_instr = r_instr;
  assign o_f_pc        = r_pc;
  assign o_f_pcplus4   = r_pc + 32'd4;
  assign o_f_adel      = r_adel;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run against a
// transaction-level model (expected pc stream plus an address-derived memory image).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall, is_jump, is_jr, branch_taken, flush;
  logic [31:0] pcjump, pcjr, pcbranch, flush_pc;
  logic        f_valid, f_adel;
  logic [31:0] f_raw_instr, f_pc, f_pcplus4;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ibus          (bus),
    .i_stall       (stall),
    .i_is_jump     (is_jump),
    .i_is_jr       (is_jr),
    .i_branch_taken(branch_taken),
    .i_pcjump      (pcjump),
    .i_pcjr        (pcjr),
    .i_pcbranch    (pcbranch),
    .i_flush       (flush),
    .i_flush_pc    (flush_pc),
    .o_f_valid     (f_valid),
    .o_f_raw_instr (f_raw_instr),
    .o_f_pc        (f_pc),
    .o_f_pcplus4   (f_pcplus4),
    .o_f_adel      (f_adel)
  );

  always #5 clk = ~clk;

  // Memory image: a bijection of the address, so stale data never matches a new pc.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] rand_target();
    int r;
    r = int'($urandom % 16);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return RESET_PC | ($urandom & 32'h0000_FFFF);
    return RESET_PC | ($urandom & 32'h0000_FFFC);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; is_jump = 0; is_jr = 0; branch_taken = 0; flush = 0;
    pcjump = 0; pcjr = 0; pcbranch = 0; flush_pc = 0;
    bus.iaddr_ok = 0; bus.idata_ok = 0; bus.irdata = 0;
  endtask

  task automatic bus_fetch(input logic [31:0] data);
    bus.iaddr_ok = 1; bus.idata_ok = 1; bus.irdata = data;
    step();
    bus.iaddr_ok = 0; bus.idata_ok = 0; bus.irdata = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    step();
    step();
    n_tests++;
    if (bus.ireq !== 1'b0 || f_valid !== 1'b0 || f_adel !== 1'b0 || f_raw_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ireq=%b f_valid=%b f_adel=%b raw=%h, want 0 0 0 0",
               bus.ireq, f_valid, f_adel, f_raw_instr);
    end
    n_tests++;
    if (bus.iaddr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_pc: got %h want %h", bus.iaddr, RESET_PC);
    end
    resetn = 1;
    #1;
    n_tests++;
    if (bus.ireq !== 1'b1 || bus.iaddr !== 32'hBFC0_0000) begin
      n_fail++;
      $display("FAIL first_req: ireq=%b iaddr=%h want 1 bfc00000", bus.ireq, bus.iaddr);
    end
  endtask

  task automatic test_basic();
    bus_fetch(32'h2402_0001);
    n_tests++;
    if (f_valid !== 1'b1 || f_pc !== 32'hBFC0_0000 || f_pcplus4 !== 32'hBFC0_0004 ||
        f_raw_instr !== 32'h2402_0001 || f_adel !== 1'b0 || bus.ireq !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_capture: v=%b pc=%h p4=%h raw=%h adel=%b ireq=%b want 1 bfc00000 bfc00004 24020001 0 0",
               f_valid, f_pc, f_pcplus4, f_raw_instr, f_adel, bus.ireq);
    end
    step();
    n_tests++;
    if (bus.ireq !== 1'b1 || bus.iaddr !== 32'hBFC0_0004 || f_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_next: ireq=%b iaddr=%h v=%b want 1 bfc00004 0", bus.ireq, bus.iaddr, f_valid);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    bus_fetch(32'h8C88_0010);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (f_valid !== 1'b1 || f_raw_instr !== 32'h8C88_0010 || f_pc !== 32'hBFC0_0004 ||
          bus.ireq !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v=%b raw=%h pc=%h ireq=%b want 1 8c880010 bfc00004 0",
                 i, f_valid, f_raw_instr, f_pc, bus.ireq);
      end
    end
    stall = 0;
    step();
    n_tests++;
    if (bus.ireq !== 1'b1 || bus.iaddr !== 32'hBFC0_0008) begin
      n_fail++;
      $display("FAIL stall_release: ireq=%b iaddr=%h want 1 bfc00008", bus.ireq, bus.iaddr);
    end
  endtask

  task automatic test_redirect();
    bus_fetch(32'h1000_0003);
    branch_taken = 1; pcbranch = 32'hBFC0_0100;
    step();
    branch_taken = 0;
    n_tests++;
    if (bus.ireq !== 1'b1 || bus.iaddr !== 32'hBFC0_0100) begin
      n_fail++;
      $display("FAIL redirect_branch: ireq=%b iaddr=%h want 1 bfc00100", bus.ireq, bus.iaddr);
    end
    bus_fetch(32'h03E0_0008);
    is_jr = 1; pcjr = 32'hBFC0_0200; is_jump = 1; pcjump = 32'hBFC0_0300;
    branch_taken = 1; pcbranch = 32'hBFC0_0400;
    step();
    is_jr = 0; is_jump = 0; branch_taken = 0;
    n_tests++;
    if (bus.iaddr !== 32'hBFC0_0200) begin
      n_fail++;
      $display("FAIL redirect_jr_prio: iaddr=%h want bfc00200", bus.iaddr);
    end
    bus_fetch(32'h0800_0010);
    is_jump = 1; pcjump = 32'hBFC0_0300; branch_taken = 1; pcbranch = 32'hBFC0_0400;
    step();
    is_jump = 0; branch_taken = 0;
    n_tests++;
    if (bus.iaddr !== 32'hBFC0_0300) begin
      n_fail++;
      $display("FAIL redirect_jump_prio: iaddr=%h want bfc00300", bus.iaddr);
    end
    // A redirect seen while stalled is not an accept and must be ignored.
    bus_fetch(32'h0000_0000);
    stall = 1; is_jump = 1; pcjump = 32'hBFC0_0700;
    step();
    stall = 0; is_jump = 0;
    step();
    n_tests++;
    if (bus.ireq !== 1'b1 || bus.iaddr !== 32'hBFC0_0304) begin
      n_fail++;
      $display("FAIL redirect_ignored: ireq=%b iaddr=%h want 1 bfc00304", bus.ireq, bus.iaddr);
    end
  endtask

  task automatic test_flush_wait();
    bus.iaddr_ok = 1;
    step();
    bus.iaddr_ok = 0;
    flush = 1; flush_pc = 32'hBFC0_0380;
    step();
    flush = 0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (bus.ireq !== 1'b0 || f_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_drain[%0d]: ireq=%b v=%b want 0 0", i, bus.ireq, f_valid);
      end
      if (i == 0) step();
    end
    bus.idata_ok = 1; bus.irdata = 32'hDEAD_BEEF;
    step();
    bus.idata_ok = 0; bus.irdata = 0;
    n_tests++;
    if (f_valid !== 1'b0 || bus.ireq !== 1'b1 || bus.iaddr !== 32'hBFC0_0380) begin
      n_fail++;
      $display("FAIL flush_restart: v=%b ireq=%b iaddr=%h want 0 1 bfc00380", f_valid, bus.ireq, bus.iaddr);
    end
    bus_fetch(32'h1111_2222);
    n_tests++;
    if (f_valid !== 1'b1 || f_raw_instr !== 32'h1111_2222 || f_pc !== 32'hBFC0_0380) begin
      n_fail++;
      $display("FAIL flush_refetch: v=%b raw=%h pc=%h want 1 11112222 bfc00380", f_valid, f_raw_instr, f_pc);
    end
  endtask

  task automatic test_adel();
    is_jr = 1; pcjr = 32'hBFC0_0102;
    step();
    is_jr = 0;
    n_tests++;
    if (bus.ireq !== 1'b0 || f_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL adel_noreq: ireq=%b v=%b want 0 0", bus.ireq, f_valid);
    end
    stall = 1;
    step();
    n_tests++;
    if (f_valid !== 1'b1 || f_adel !== 1'b1 || f_raw_instr !== 32'h0 || f_pc !== 32'hBFC0_0102 ||
        bus.ireq !== 1'b0) begin
      n_fail++;
      $display("FAIL adel_entry: v=%b adel=%b raw=%h pc=%h ireq=%b want 1 1 0 bfc00102 0",
               f_valid, f_adel, f_raw_instr, f_pc, bus.ireq);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, bus_addr, exp_raw;
    logic        exp_adel;
    bit          pending, exp_idle;
    int          delay, gap, max_gap, accepts;
    resetn = 0;
    clear_inputs();
    step();
    step();
    resetn = 1;
    #1;
    m_pc = RESET_PC; bus_addr = 0; pending = 0; exp_idle = 0;
    delay = 0; gap = 0; max_gap = 0; accepts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (exp_idle) begin
        n_tests++;
        if (f_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_flush_drop cyc %0d: v=%b want 0", cyc, f_valid);
        end
      end
      if (f_valid === 1'b1) begin
        exp_adel = (m_pc[1:0] != 2'b00);
        exp_raw  = exp_adel ? 32'h0 : mem(m_pc);
        n_tests++;
        if (f_pc !== m_pc || f_pcplus4 !== m_pc + 32'd4 || f_raw_instr !== exp_raw ||
            f_adel !== exp_adel) begin
          n_fail++;
          $display("FAIL rand_entry cyc %0d: pc=%h p4=%h raw=%h adel=%b want %h %h %h %b", cyc,
                   f_pc, f_pcplus4, f_raw_instr, f_adel, m_pc, m_pc + 32'd4, exp_raw, exp_adel);
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (gap > max_gap) max_gap = gap;
      if (pending) begin
        n_tests++;
        if (bus.ireq !== 1'b0 || f_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_inflight cyc %0d: ireq=%b v=%b want 0 0", cyc, bus.ireq, f_valid);
        end
      end else if (m_pc[1:0] != 2'b00) begin
        n_tests++;
        if (bus.ireq !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_misaligned_req cyc %0d: ireq=%b want 0", cyc, bus.ireq);
        end
      end
      if (bus.ireq === 1'b1) begin
        n_tests++;
        if (bus.iaddr !== m_pc) begin
          n_fail++;
          $display("FAIL rand_iaddr cyc %0d: got %h want %h", cyc, bus.iaddr, m_pc);
        end
      end

      stall        = ($urandom % 10) < 3;
      is_jr        = ($urandom % 4) == 0;
      is_jump      = ($urandom % 4) == 0;
      branch_taken = ($urandom % 4) == 0;
      pcjr         = rand_target();
      pcjump       = rand_target();
      pcbranch     = rand_target();
      flush        = ($urandom % 25) == 0;
      flush_pc     = rand_target();

      // Memory slave: random address acceptance and 0..3 cycle data latency.
      bus.iaddr_ok = 0; bus.idata_ok = 0; bus.irdata = $urandom;
      if (pending) begin
        if (delay == 0) begin
          bus.idata_ok = 1; bus.irdata = mem(bus_addr); pending = 0;
        end else begin
          delay--;
        end
      end else if (bus.ireq === 1'b1 && ($urandom % 3) != 0) begin
        bus.iaddr_ok = 1;
        bus_addr = bus.iaddr;
        delay = int'($urandom % 4);
        if (delay == 0) begin
          bus.idata_ok = 1; bus.irdata = mem(bus_addr);
        end else begin
          pending = 1; delay--;
        end
      end

      exp_idle = flush;
      if (flush) begin
        m_pc = flush_pc;
      end else if (f_valid === 1'b1 && !stall) begin
        accepts++;
        if (is_jr)             m_pc = pcjr;
        else if (is_jump)      m_pc = pcjump;
        else if (branch_taken) m_pc = pcbranch;
        else                   m_pc = m_pc + 32'd4;
      end
      step();
    end
    clear_inputs();
    n_tests++;
    if (accepts < 200) begin
      n_fail++;
      $display("FAIL rand_progress: accepts=%0d want >= 200", accepts);
    end
    n_tests++;
    if (max_gap > 60) begin
      n_fail++;
      $display("FAIL rand_liveness: max cycles without f_valid=%0d want <= 60", max_gap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_flush_wait();
    test_adel();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
